// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin scheduler in front of the RMII TX controller.
// Pulses a start per grant, detects completion, enforces the IFG and a watchdog.
module eth_tx_sched #(
  parameter int pNum_Req     = 4,
  parameter int pIFG_Cnt     = 48,
  parameter int pTimeout_Cnt = 4095,
  parameter int pIdle_Code   = 0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [pNum_Req-1:0] Req,
  input  logic [3:0]          Tx_Ctrl_FSM_State,
  output logic                Eth_En,
  output logic [pNum_Req-1:0] Grant,
  output logic [2:0]          Grant_Id,
  output logic                Busy,
  output logic                Done,
  output logic                Timeout_Err
);
  localparam int WD_W  = $clog2(pTimeout_Cnt + 1);
  localparam int IFG_W = $clog2(pIFG_Cnt + 1);
  localparam logic [3:0] IDLE_CODE = 4'(pIdle_Code);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_ACTIVE, S_IFG} state_t;

  state_t              state, state_nxt;
  logic [2:0]          ptr, ptr_nxt;
  logic [WD_W-1:0]     wd, wd_nxt;
  logic [IFG_W-1:0]    ifg_cnt, ifg_nxt;
  logic                eth_en_nxt, busy_nxt, done_nxt, to_nxt;
  logic [pNum_Req-1:0] grant_nxt;
  logic [2:0]          grant_id_nxt;

  logic tx_idle, wd_exp, ifg_last, req_any;
  assign tx_idle  = (Tx_Ctrl_FSM_State == IDLE_CODE);
  assign wd_exp   = (wd == WD_W'(pTimeout_Cnt - 1));
  assign ifg_last = (ifg_cnt == IFG_W'(pIFG_Cnt - 1));
  assign req_any  = |Req;

  // Rotate the doubled request vector so bit 0 is the pointer position;
  // the lowest set bit is the winner's offset from the pointer.
  logic [2*pNum_Req-1:0] req_rot;
  logic [3:0]            off, win_sum;
  logic [2:0]            win;
  always_comb begin
    req_rot = {Req, Req} >> ptr;
    off     = '0;
    for (int i = 2*pNum_Req-1; i >= 0; i--)
      if (req_rot[i]) off = 4'(i);
    win_sum = {1'b0, ptr} + off;
    win     = (win_sum >= 4'(pNum_Req)) ? 3'(win_sum - 4'(pNum_Req)) : win_sum[2:0];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wd          <= '0;
      ifg_cnt     <= '0;
      Eth_En      <= 1'b0;
      Grant       <= '0;
      Grant_Id    <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      wd          <= wd_nxt;
      ifg_cnt     <= ifg_nxt;
      Eth_En      <= eth_en_nxt;
      Grant       <= grant_nxt;
      Grant_Id    <= grant_id_nxt;
      Busy        <= busy_nxt;
      Done        <= done_nxt;
      Timeout_Err <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (req_any) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (wd_exp) state_nxt = S_IFG;
                  else if (!tx_idle) state_nxt = S_ACTIVE;
      S_ACTIVE:   if (tx_idle || wd_exp) state_nxt = S_IFG;
      S_IFG:      if (ifg_last) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    eth_en_nxt   = 1'b0;
    done_nxt     = 1'b0;
    to_nxt       = 1'b0;
    grant_nxt    = Grant;
    grant_id_nxt = Grant_Id;
    busy_nxt     = Busy;
    ptr_nxt      = ptr;
    wd_nxt       = wd;
    ifg_nxt      = ifg_cnt;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          grant_nxt    = {{(pNum_Req-1){1'b0}}, 1'b1} << win;
          grant_id_nxt = win;
          eth_en_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          wd_nxt       = '0;
          ptr_nxt      = (win == 3'(pNum_Req - 1)) ? 3'd0 : win + 3'd1;
        end
      end
      S_WAIT_ACK: begin
        wd_nxt = wd + WD_W'(1);
        if (wd_exp) begin
          to_nxt    = 1'b1;
          grant_nxt = '0;
          ifg_nxt   = '0;
        end
      end
      S_ACTIVE: begin
        wd_nxt = wd + WD_W'(1);
        // Completion wins over a watchdog expiry on the same cycle.
        if (tx_idle) begin
          done_nxt  = 1'b1;
          grant_nxt = '0;
          ifg_nxt   = '0;
        end else if (wd_exp) begin
          to_nxt    = 1'b1;
          grant_nxt = '0;
          ifg_nxt   = '0;
        end
      end
      S_IFG: begin
        if (ifg_last) busy_nxt = 1'b0;
        else          ifg_nxt  = ifg_cnt + IFG_W'(1);
      end
      default: ;
    endcase
  end
endmodule
